// File: rtl/sensor_pkg.sv
// Shared constants for the irrigation sensor input conditioning stage.
package sensor_pkg;

  localparam int N_CH              = 6;
  localparam int DEFAULT_DB_CYCLES = 50000;  // 1 ms at 50 MHz

  localparam int CH_L  = 0;
  localparam int CH_M  = 1;
  localparam int CH_H  = 2;
  localparam int CH_T  = 3;
  localparam int CH_UA = 4;
  localparam int CH_US = 5;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchroniser, debounce counter and clean level.
module debounce_channel #(
  parameter int   DB_CYCLES = sensor_pkg::DEFAULT_DB_CYCLES,
  parameter int   CNT_W     = $clog2(DB_CYCLES + 1),
  parameter logic RST_BIT   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic clean_o,
  output logic flip_o,
  output logic idle_o
);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s1_d    = raw_i;
    s2_d    = s1_q;
    clean_d = clean_q;
    cnt_d   = '0;
    flip_o  = 1'b0;
    if (s2_q != clean_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        clean_d = s2_q;
        flip_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Next-state view lets the top register 'stable' in the settling cycle.
    idle_o = (s2_d == clean_d) && (cnt_d == '0);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // pre-edge values; the async reset also clears any partial count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= RST_BIT;
      s2_q    <= RST_BIT;
      clean_q <= RST_BIT;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/sensor_debouncer.sv
// Debounces the six raw level/temperature/humidity inputs and reports
// change pulses, a saturating change count and an all-stable flag.
module sensor_debouncer #(
  parameter int              N_CH      = sensor_pkg::N_CH,
  parameter int              DB_CYCLES = sensor_pkg::DEFAULT_DB_CYCLES,
  parameter int              CNT_W     = $clog2(DB_CYCLES + 1),
  parameter logic [N_CH-1:0] RST_VAL   = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic            changed,
  output logic            stable,
  output logic [7:0]      change_count
);

  logic [N_CH-1:0] flip;
  logic [N_CH-1:0] idle;

  logic       changed_q, changed_d;
  logic       stable_q, stable_d;
  logic [7:0] count_q, count_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W),
      .RST_BIT   (RST_VAL[i])
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (raw_in[i]),
      .clean_o (clean_out[i]),
      .flip_o  (flip[i]),
      .idle_o  (idle[i])
    );
  end

  // Simultaneous flips in several channels count as one change event.
  always_comb begin
    changed_d = |flip;
    stable_d  = &idle;
    count_d   = count_q;
    if (changed_d && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      changed_q <= 1'b0;
      stable_q  <= 1'b1;
      count_q   <= 8'd0;
    end else begin
      changed_q <= changed_d;
      stable_q  <= stable_d;
      count_q   <= count_d;
    end
  end

  assign changed      = changed_q;
  assign stable       = stable_q;
  assign change_count = count_q;

endmodule
